// File: rtl/i2c_burst_control.sv
// Register-access sequencer over a byte-level I2C engine; optional NACK retry via I2C_CTRL_RETRY_EN.
// Latency: Go one cycle after acceptance, next Go one cycle after each Trans_Done, RW_Done one cycle after the last.
// Backpressure: one transaction at a time; requests seen while busy are dropped, never queued.
module i2c_burst_control #(
  parameter int ADDR_BYTES_MAX = 2,
  parameter int DATA_BYTES_MAX = 4,
  parameter int RETRY_MAX      = 3
) (
  input  logic                                  Clk,
  input  logic                                  Rst_n,
  input  logic                                  wrreg_req,
  input  logic                                  rdreg_req,
  input  logic [6:0]                            dev_addr,
  input  logic [8*ADDR_BYTES_MAX-1:0]           addr,
  input  logic [$clog2(ADDR_BYTES_MAX+1)-1:0]   addr_bytes,
  input  logic [$clog2(DATA_BYTES_MAX+1)-1:0]   len,
  input  logic [8*DATA_BYTES_MAX-1:0]           wrdata,
  output logic [8*DATA_BYTES_MAX-1:0]           rddata,
  output logic                                  busy,
  output logic                                  RW_Done,
  output logic                                  ack,
  output logic [5:0]                            Cmd,
  output logic                                  Go,
  output logic [7:0]                            Tx_DATA,
  input  logic [7:0]                            Rx_DATA,
  input  logic                                  Trans_Done,
  input  logic                                  ack_o
);

  localparam int AW = $clog2(ADDR_BYTES_MAX + 1);
  localparam int LW = $clog2(DATA_BYTES_MAX + 1);
  localparam int SW = $clog2(ADDR_BYTES_MAX + DATA_BYTES_MAX + 3);
  localparam logic [AW-1:0] AB_MAX  = AW'(ADDR_BYTES_MAX);
  localparam logic [LW-1:0] LEN_MAX = LW'(DATA_BYTES_MAX);

  localparam logic [5:0] CMD_WR   = 6'b000001;
  localparam logic [5:0] CMD_STA  = 6'b000010;
  localparam logic [5:0] CMD_RD   = 6'b000100;
  localparam logic [5:0] CMD_STO  = 6'b001000;
  localparam logic [5:0] CMD_ACK  = 6'b010000;
  localparam logic [5:0] CMD_NACK = 6'b100000;

  if (ADDR_BYTES_MAX < 1 || DATA_BYTES_MAX < 1 || RETRY_MAX < 0) begin : g_param_check
    $error("i2c_burst_control: parameters out of range");
  end

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, STOP_ISSUE, STOP_WAIT, DONE} state_t;

  typedef struct packed {
    logic                        rd;
    logic [6:0]                  dev;
    logic [AW-1:0]               ab;
    logic [LW-1:0]               len;
    logic [8*ADDR_BYTES_MAX-1:0] addr;
    logic [8*DATA_BYTES_MAX-1:0] wdat;
  } req_t;

  state_t                      state;
  req_t                        req;
  logic [SW-1:0]               step;
  logic [LW-1:0]               byte_cnt;
  logic [8*DATA_BYTES_MAX-1:0] shadow;

  logic [AW-1:0] ab_n;
  logic [LW-1:0] len_n;
  logic [SW-1:0] ab_s, aidx;
  logic [7:0]    addr_byte, data_byte, step_tx;
  logic [5:0]    step_cmd;
  logic          step_rd, step_last, step_data, last_byte, can_retry;

`ifdef I2C_CTRL_RETRY_EN
  localparam int RW = $clog2(RETRY_MAX + 2);
  logic [RW-1:0] retry_cnt;
  assign can_retry = (retry_cnt < RW'(RETRY_MAX));
`else
  assign can_retry = 1'b0;
`endif

  always_comb begin
    ab_n = addr_bytes;
    if (addr_bytes == '0)        ab_n = AW'(1);
    else if (addr_bytes > AB_MAX) ab_n = AB_MAX;
    len_n = len;
    if (len == '0)          len_n = LW'(1);
    else if (len > LEN_MAX) len_n = LEN_MAX;
  end

  // Step map: 0 = device write address, 1..ab = address bytes MSB first,
  // then data (write) or repeated-start device read address followed by reads.
  always_comb begin
    ab_s      = SW'(req.ab);
    aidx      = ab_s - step;
    addr_byte = 8'h00;
    data_byte = 8'h00;
    for (int i = 0; i < ADDR_BYTES_MAX; i++)
      if (aidx == SW'(i)) addr_byte = req.addr[8*i +: 8];
    for (int i = 0; i < DATA_BYTES_MAX; i++)
      if (byte_cnt == LW'(i)) data_byte = req.wdat[8*i +: 8];
    last_byte = (byte_cnt == req.len - LW'(1));
    step_cmd  = CMD_WR;
    step_tx   = 8'h00;
    step_rd   = 1'b0;
    step_last = 1'b0;
    step_data = 1'b0;
    if (step == '0) begin
      step_cmd = CMD_STA | CMD_WR;
      step_tx  = {req.dev, 1'b0};
    end else if (step <= ab_s) begin
      step_tx = addr_byte;
    end else if (!req.rd) begin
      step_data = 1'b1;
      step_tx   = data_byte;
      step_last = last_byte;
      if (last_byte) step_cmd = CMD_WR | CMD_STO;
    end else if (step == ab_s + SW'(1)) begin
      step_cmd = CMD_STA | CMD_WR;
      step_tx  = {req.dev, 1'b1};
    end else begin
      step_data = 1'b1;
      step_rd   = 1'b1;
      step_last = last_byte;
      step_cmd  = last_byte ? (CMD_RD | CMD_NACK | CMD_STO) : (CMD_RD | CMD_ACK);
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      req       <= '0;
      step      <= '0;
      byte_cnt  <= '0;
      shadow    <= '0;
      rddata    <= '0;
      busy      <= 1'b0;
      RW_Done   <= 1'b0;
      ack       <= 1'b0;
      Cmd       <= '0;
      Go        <= 1'b0;
      Tx_DATA   <= '0;
`ifdef I2C_CTRL_RETRY_EN
      retry_cnt <= '0;
`endif
    end else begin
      Go      <= 1'b0;
      RW_Done <= 1'b0;
      case (state)
        IDLE: if (wrreg_req || rdreg_req) begin
          req       <= '{rd: !wrreg_req, dev: dev_addr, ab: ab_n, len: len_n, addr: addr, wdat: wrdata};
          step      <= '0;
          byte_cnt  <= '0;
          shadow    <= '0;
          ack       <= 1'b0;
          busy      <= 1'b1;
`ifdef I2C_CTRL_RETRY_EN
          retry_cnt <= '0;
`endif
          state     <= ISSUE;
        end
        ISSUE: begin
          Cmd     <= step_cmd;
          Tx_DATA <= step_tx;
          Go      <= 1'b1;
          state   <= WAIT;
        end
        WAIT: if (Trans_Done) begin
          if (!step_rd && ack_o) begin
            ack <= 1'b1;
            // A NACKed byte that already carried STO leaves the bus stopped.
            if (!step_last) begin
              state <= STOP_ISSUE;
            end else if (can_retry) begin
              step     <= '0;
              byte_cnt <= '0;
              shadow   <= '0;
              ack      <= 1'b0;
`ifdef I2C_CTRL_RETRY_EN
              retry_cnt <= retry_cnt + RW'(1);
`endif
              state    <= ISSUE;
            end else begin
              state <= DONE;
            end
          end else begin
            if (step_rd)
              for (int i = 0; i < DATA_BYTES_MAX; i++)
                if (byte_cnt == LW'(i)) shadow[8*i +: 8] <= Rx_DATA;
            if (step_last) begin
              state <= DONE;
            end else begin
              step <= step + SW'(1);
              if (step_data && byte_cnt != LEN_MAX) byte_cnt <= byte_cnt + LW'(1);
              state <= ISSUE;
            end
          end
        end
        STOP_ISSUE: begin
          Cmd   <= CMD_STO;
          Go    <= 1'b1;
          state <= STOP_WAIT;
        end
        STOP_WAIT: if (Trans_Done) begin
          if (can_retry) begin
            step     <= '0;
            byte_cnt <= '0;
            shadow   <= '0;
            ack      <= 1'b0;
`ifdef I2C_CTRL_RETRY_EN
            retry_cnt <= retry_cnt + RW'(1);
`endif
            state    <= ISSUE;
          end else begin
            state <= DONE;
          end
        end
        DONE: begin
          RW_Done <= 1'b1;
          busy    <= 1'b0;
          if (req.rd && !ack) rddata <= shadow;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_burst_control.sv
// Bench for i2c_burst_control: behavioural byte engine, command scoreboard and cycle-timing monitor.
`timescale 1ns/1ps
module tb_i2c_burst_control;
  localparam int AMAX = 2;
  localparam int DMAX = 4;

  logic        Clk = 1'b0, Rst_n = 1'b0;
  logic        wrreg_req = 1'b0, rdreg_req = 1'b0;
  logic [6:0]  dev_addr = '0;
  logic [15:0] addr = '0;
  logic [1:0]  addr_bytes = '0;
  logic [2:0]  len = '0;
  logic [31:0] wrdata = '0;
  logic [31:0] rddata;
  logic        busy, RW_Done, ack, Go;
  logic [5:0]  Cmd;
  logic [7:0]  Tx_DATA;
  logic [7:0]  Rx_DATA = '0;
  logic        Trans_Done = 1'b0, ack_o = 1'b0;

  always #5 Clk = ~Clk;

  i2c_burst_control #(.ADDR_BYTES_MAX(AMAX), .DATA_BYTES_MAX(DMAX), .RETRY_MAX(3)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .wrreg_req(wrreg_req), .rdreg_req(rdreg_req),
    .dev_addr(dev_addr), .addr(addr), .addr_bytes(addr_bytes), .len(len), .wrdata(wrdata),
    .rddata(rddata), .busy(busy), .RW_Done(RW_Done), .ack(ack), .Cmd(Cmd), .Go(Go),
    .Tx_DATA(Tx_DATA), .Rx_DATA(Rx_DATA), .Trans_Done(Trans_Done), .ack_o(ack_o));

  typedef struct packed { logic [5:0] cmd; logic [7:0] tx; logic care; } step_t;
  step_t      exp_q[$], obs_q[$];
  logic [7:0] rx_q[$];
  int checks = 0, errors = 0;
  int go_idx = 0, nack_idx = -1;
  int go_bad = 0, rw_bad = 0, rw_cnt = 0;

  // Byte engine: answers each Go after 0..2 extra cycles; NACKs the Go numbered nack_idx.
  initial begin : engine
    int dly;
    bit pend;
    step_t cur;
    pend = 1'b0; dly = 0; cur = '0;
    forever begin
      @(negedge Clk);
      Trans_Done = 1'b0;
      ack_o = 1'b0;
      if (!Rst_n) pend = 1'b0;
      else begin
        if (Go === 1'b1 && !pend) begin
          cur = '{Cmd, Tx_DATA, 1'b1};
          obs_q.push_back(cur);
          pend = 1'b1;
          dly = $urandom_range(0, 2);
        end
        if (pend) begin
          if (dly == 0) begin
            pend = 1'b0;
            Trans_Done = 1'b1;
            ack_o = (go_idx == nack_idx);
            if (cur.cmd[2] && rx_q.size() > 0) Rx_DATA = rx_q.pop_front();
            else Rx_DATA = 8'($urandom);
            go_idx++;
          end else dly--;
        end
      end
    end
  end

  // Every Go must follow a Trans_Done or acceptance by one cycle; RW_Done one cycle after Trans_Done.
  initial begin : monitor
    bit td_p, busy_p, busy_pp, go_p, rw_p;
    td_p = 0; busy_p = 0; busy_pp = 0; go_p = 0; rw_p = 0;
    forever begin
      @(posedge Clk); #1;
      if (Go === 1'b1 && (!(td_p || (busy_p && !busy_pp)) || go_p)) go_bad++;
      if (RW_Done === 1'b1) begin
        rw_cnt++;
        if (!td_p || rw_p) rw_bad++;
      end
      td_p = Trans_Done; busy_pp = busy_p; busy_p = busy; go_p = Go; rw_p = RW_Done;
    end
  end

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge Clk); #1;
      if (RW_Done === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic issue(input bit rd, input logic [6:0] d, input logic [15:0] a,
                       input logic [1:0] ab, input logic [2:0] l, input logic [31:0] w);
    @(negedge Clk);
    dev_addr = d; addr = a; addr_bytes = ab; len = l; wrdata = w;
    wrreg_req = !rd; rdreg_req = rd;
    @(negedge Clk);
    wrreg_req = 1'b0; rdreg_req = 1'b0;
  endtask

  // Reference sequence for one transaction, with length clamping applied.
  task automatic push_exp(input bit rd, input logic [6:0] d, input logic [15:0] a,
                          input int ab, input int l, input logic [31:0] w);
    int nab, nl;
    nab = (ab == 0) ? 1 : ((ab > AMAX) ? AMAX : ab);
    nl  = (l == 0) ? 1 : ((l > DMAX) ? DMAX : l);
    exp_q.push_back('{6'b000011, {d, 1'b0}, 1'b1});
    for (int i = nab - 1; i >= 0; i--) exp_q.push_back('{6'b000001, 8'(a >> (8*i)), 1'b1});
    if (!rd) begin
      for (int k = 0; k < nl; k++)
        exp_q.push_back('{(k == nl-1) ? 6'b001001 : 6'b000001, 8'(w >> (8*k)), 1'b1});
    end else begin
      exp_q.push_back('{6'b000011, {d, 1'b1}, 1'b1});
      for (int k = 0; k < nl; k++)
        exp_q.push_back('{(k == nl-1) ? 6'b101100 : 6'b010100, 8'h00, 1'b0});
    end
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({Cmd, Go, Tx_DATA, rddata, busy, RW_Done, ack} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got Cmd=%b Go=%b Tx=%h rd=%h busy=%b done=%b ack=%b want all zero",
               Cmd, Go, Tx_DATA, rddata, busy, RW_Done, ack);
    end
    @(negedge Clk); Rst_n = 1'b1;
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_write_2b;
    bit ok; int rw0; step_t e, o;
    rw0 = rw_cnt;
    exp_q.push_back('{6'b000011, 8'h78, 1'b1});
    exp_q.push_back('{6'b000001, 8'h30, 1'b1});
    exp_q.push_back('{6'b000001, 8'h08, 1'b1});
    exp_q.push_back('{6'b001001, 8'h82, 1'b1});
    @(negedge Clk);
    dev_addr = 7'h3C; addr = 16'h3008; addr_bytes = 2'd2; len = 3'd1; wrdata = 32'h82;
    wrreg_req = 1'b1;
    @(posedge Clk); #1;
    checks++;
    if (busy !== 1'b1 || Go !== 1'b0) begin
      errors++; $display("FAIL start_busy got busy=%b Go=%b want busy=1 Go=0", busy, Go);
    end
    @(posedge Clk); #1;
    checks++;
    if (Go !== 1'b1 || Cmd !== 6'b000011 || Tx_DATA !== 8'h78) begin
      errors++; $display("FAIL start_go got Go=%b Cmd=%b Tx=%h want 1/000011/78", Go, Cmd, Tx_DATA);
    end
    @(negedge Clk); wrreg_req = 1'b0;
    wait_done(ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL wr2_timeout got no RW_Done want RW_Done"); end
    checks++;
    if (ack !== 1'b0 || rddata !== 32'h0) begin
      errors++; $display("FAIL wr2_status got ack=%b rddata=%h want 0/00000000", ack, rddata);
    end
    repeat (3) @(negedge Clk);
    checks++;
    if (rw_cnt - rw0 !== 1) begin errors++; $display("FAIL wr2_done_count got %0d want 1", rw_cnt - rw0); end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL wr2_steps got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.cmd !== e.cmd || (e.care && o.tx !== e.tx)) begin
        errors++; $display("FAIL wr2_step got %b/%h want %b/%h", o.cmd, o.tx, e.cmd, e.tx);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_burst_read;
    bit ok; step_t e, o;
    rx_q.push_back(8'h11); rx_q.push_back(8'h22); rx_q.push_back(8'h33);
    exp_q.push_back('{6'b000011, 8'h78, 1'b1});
    exp_q.push_back('{6'b000001, 8'h0A, 1'b1});
    exp_q.push_back('{6'b000011, 8'h79, 1'b1});
    exp_q.push_back('{6'b010100, 8'h00, 1'b0});
    exp_q.push_back('{6'b010100, 8'h00, 1'b0});
    exp_q.push_back('{6'b101100, 8'h00, 1'b0});
    issue(1'b1, 7'h3C, 16'h000A, 2'd1, 3'd3, 32'h0);
    wait_done(ok);
    checks++;
    if (ok !== 1'b1 || ack !== 1'b0 || rddata !== 32'h00332211) begin
      errors++; $display("FAIL rd3_result got done=%b ack=%b rddata=%h want 1/0/00332211", ok, ack, rddata);
    end
    @(negedge Clk);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL rd3_steps got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.cmd !== e.cmd || (e.care && o.tx !== e.tx)) begin
        errors++; $display("FAIL rd3_step got %b/%h want %b/%h", o.cmd, o.tx, e.cmd, e.tx);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

`ifdef I2C_CTRL_RETRY_EN
  task automatic test_nack_retry;
    bit ok; int rw0; step_t e, o;
    rw0 = rw_cnt;
    nack_idx = go_idx + 1;
    exp_q.push_back('{6'b000011, 8'h78, 1'b1});
    exp_q.push_back('{6'b000001, 8'h30, 1'b1});
    exp_q.push_back('{6'b001000, 8'h00, 1'b0});
    push_exp(1'b0, 7'h3C, 16'h3008, 2, 1, 32'h82);
    issue(1'b0, 7'h3C, 16'h3008, 2'd2, 3'd1, 32'h82);
    wait_done(ok);
    checks++;
    if (ok !== 1'b1 || ack !== 1'b0) begin
      errors++; $display("FAIL retry_result got done=%b ack=%b want 1/0", ok, ack);
    end
    repeat (3) @(negedge Clk);
    nack_idx = -1;
    checks++;
    if (rw_cnt - rw0 !== 1) begin errors++; $display("FAIL retry_done_count got %0d want 1", rw_cnt - rw0); end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL retry_steps got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.cmd !== e.cmd || (e.care && o.tx !== e.tx)) begin
        errors++; $display("FAIL retry_step got %b/%h want %b/%h", o.cmd, o.tx, e.cmd, e.tx);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask
`else
  task automatic test_nack_abort;
    bit ok; int rw0; step_t e, o;
    rw0 = rw_cnt;
    nack_idx = go_idx + 2;
    exp_q.push_back('{6'b000011, 8'h78, 1'b1});
    exp_q.push_back('{6'b000001, 8'h12, 1'b1});
    exp_q.push_back('{6'b000001, 8'h34, 1'b1});
    exp_q.push_back('{6'b001000, 8'h00, 1'b0});
    issue(1'b1, 7'h3C, 16'h1234, 2'd2, 3'd2, 32'h0);
    wait_done(ok);
    checks++;
    if (ok !== 1'b1 || ack !== 1'b1 || rddata !== 32'h00332211) begin
      errors++; $display("FAIL nack_result got done=%b ack=%b rddata=%h want 1/1/00332211", ok, ack, rddata);
    end
    repeat (3) @(negedge Clk);
    nack_idx = -1;
    checks++;
    if (rw_cnt - rw0 !== 1) begin errors++; $display("FAIL nack_done_count got %0d want 1", rw_cnt - rw0); end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL nack_steps got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.cmd !== e.cmd || (e.care && o.tx !== e.tx)) begin
        errors++; $display("FAIL nack_step got %b/%h want %b/%h", o.cmd, o.tx, e.cmd, e.tx);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask
`endif

  task automatic test_back_to_back;
    bit ok; int rw0; step_t e, o;
    rw0 = rw_cnt;
    push_exp(1'b0, 7'h50, 16'h00AB, 1, 2, 32'hBEEF);
    issue(1'b0, 7'h50, 16'h00AB, 2'd1, 3'd2, 32'hBEEF);
    repeat (2) @(negedge Clk);
    rdreg_req = 1'b1;
    @(negedge Clk);
    rdreg_req = 1'b0;
    dev_addr = 7'h51; addr = 16'h00CD; len = 3'd1; wrdata = 32'h5A;
    wrreg_req = 1'b1;
    push_exp(1'b0, 7'h51, 16'h00CD, 1, 1, 32'h5A);
    wait_done(ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL b2b_first_timeout got no RW_Done want RW_Done"); end
    @(posedge Clk); #1;
    checks++;
    if (busy !== 1'b1 || Go !== 1'b0) begin
      errors++; $display("FAIL b2b_accept got busy=%b Go=%b want 1/0", busy, Go);
    end
    @(posedge Clk); #1;
    checks++;
    if (Go !== 1'b1 || Cmd !== 6'b000011 || Tx_DATA !== 8'hA2) begin
      errors++; $display("FAIL b2b_go got Go=%b Cmd=%b Tx=%h want 1/000011/a2", Go, Cmd, Tx_DATA);
    end
    @(negedge Clk); wrreg_req = 1'b0;
    wait_done(ok);
    repeat (3) @(negedge Clk);
    checks++;
    if (ok !== 1'b1 || rw_cnt - rw0 !== 2) begin
      errors++; $display("FAIL b2b_done_count got done=%b count=%0d want 1/2", ok, rw_cnt - rw0);
    end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL b2b_steps got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.cmd !== e.cmd || (e.care && o.tx !== e.tx)) begin
        errors++; $display("FAIL b2b_step got %b/%h want %b/%h", o.cmd, o.tx, e.cmd, e.tx);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_len0;
    bit ok, seen; step_t e, o;
    rx_q.push_back(8'h01); rx_q.push_back(8'h02);
    issue(1'b1, 7'h3C, 16'h0055, 2'd1, 3'd2, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge Clk); #1;
      if (Go === 1'b1) seen = 1'b1;
    end
    @(posedge Clk); #2;
    Rst_n = 1'b0;
    #1;
    checks++;
    if (!seen || {Cmd, Go, Tx_DATA, rddata, busy, RW_Done, ack} !== '0) begin
      errors++;
      $display("FAIL midreset got seen=%b Cmd=%b Go=%b Tx=%h rd=%h busy=%b done=%b ack=%b want seen=1 rest zero",
               seen, Cmd, Go, Tx_DATA, rddata, busy, RW_Done, ack);
    end
    @(negedge Clk); Rst_n = 1'b1;
    @(negedge Clk);
    obs_q.delete(); rx_q.delete(); exp_q.delete();
    push_exp(1'b0, 7'h22, 16'h0077, 0, 0, 32'hA5);
    issue(1'b0, 7'h22, 16'h0077, 2'd0, 3'd0, 32'hA5);
    wait_done(ok);
    checks++;
    if (ok !== 1'b1 || ack !== 1'b0) begin
      errors++; $display("FAIL len0_write got done=%b ack=%b want 1/0", ok, ack);
    end
    rx_q.push_back(8'h9C);
    push_exp(1'b1, 7'h22, 16'h0077, 1, 0, 32'h0);
    issue(1'b1, 7'h22, 16'h0077, 2'd1, 3'd0, 32'h0);
    wait_done(ok);
    checks++;
    if (ok !== 1'b1 || rddata !== 32'h0000009C) begin
      errors++; $display("FAIL len0_read got done=%b rddata=%h want 1/0000009c", ok, rddata);
    end
    push_exp(1'b0, 7'h22, 16'hA1B2, 3, 7, 32'h44332211);
    issue(1'b0, 7'h22, 16'hA1B2, 2'd3, 3'd7, 32'h44332211);
    wait_done(ok);
    repeat (3) @(negedge Clk);
    checks++;
    if (ok !== 1'b1 || go_bad !== 0 || rw_bad !== 0) begin
      errors++; $display("FAIL clamp_timing got done=%b go_bad=%0d rw_bad=%0d want 1/0/0", ok, go_bad, rw_bad);
    end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL clamp_steps got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.cmd !== e.cmd || (e.care && o.tx !== e.tx)) begin
        errors++; $display("FAIL clamp_step got %b/%h want %b/%h", o.cmd, o.tx, e.cmd, e.tx);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_write_2b();
    test_burst_read();
`ifdef I2C_CTRL_RETRY_EN
    test_nack_retry();
`else
    test_nack_abort();
`endif
    test_back_to_back();
    test_reset_len0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
